// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access master.
// Holds the FSM state encoding, frame geometry and the read/write encodings
// used both on the RNW input and in the first bit of the serial frame.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int FRAME_LEN    = 16;
  localparam int RD_FIRST_BIT = 8;   // first frame bit carrying read data

  // RNW input encoding
  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

  // First frame bit encoding (inverse of RNW)
  localparam logic FRAME_BIT0_WRITE = 1'b1;
  localparam logic FRAME_BIT0_READ  = 1'b0;

  // Frame layout, transmitted MSB first: {rw bit, addr[6:0], data[7:0]}.
  // Reads send zeros in the data field.
  function automatic logic [15:0] build_frame(input logic       rnw,
                                              input logic [6:0] addr,
                                              input logic [7:0] wd);
    logic       bit0;
    logic [7:0] data;
    bit0 = (rnw == RNW_READ) ? FRAME_BIT0_READ : FRAME_BIT0_WRITE;
    data = (rnw == RNW_READ) ? 8'h00 : wd;
    return {bit0, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for the SPI master.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high; counter and phase clear while low
//   rise_o     : strobe on odd half-period ticks (1st, 3rd, ...)
//   fall_o     : strobe on even half-period ticks (2nd, 4th, ...)
// The first tick arrives CLK_DIV cycles after en rises.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       tick;

  assign tick   = en && (cnt_q == DIV_M1);
  assign rise_o = tick && !phase_q;
  assign fall_o = tick &&  phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = 8'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master for 16-bit register frames {~rnw, addr[6:0], data[7:0]}.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   req, rnw, addr, wd: transaction request; fields captured when accepted
//   rd                : read data, updated on the DONE cycle of a read
//   busy, done        : status / single-cycle completion pulse
//   sclk, mosi, csn   : SPI outputs (sclk idle low, csn idle high)
//   miso              : SPI input
//   dbg_state         : current FSM state encoding
// Handshake: req is a strobe honoured only when the FSM is idle and not in the
// done cycle; any req seen at other times is dropped, never queued.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rnw,
  input  logic [6:0] addr,
  input  logic [7:0] wd,
  output logic [7:0] rd,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       csn,
  output logic [2:0] dbg_state
);

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_q, rd_d;
  logic        rnw_q, rnw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        csn_q, csn_d;
  logic        rise, fall;
  logic [15:0] frame_in;

  assign frame_in = build_frame(rnw, addr, wd);

  // Ticks alternate rise/fall from the first one: tick 1 starts bit 0,
  // ticks 1..32 are the 16 SCLK pulses, tick 33 (a "rise" slot) ends HOLD
  // and tick 34 (a "fall" slot) ends GAP.
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q != ST_IDLE),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    rnw_d     = rnw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    case (state_q)
      ST_IDLE: begin
        if (done_q) begin
          busy_d = 1'b0;
        end else if (req) begin
          state_d   = ST_SETUP;
          rnw_d     = rnw;
          tx_d      = frame_in;
          mosi_d    = frame_in[15];
          rx_d      = 8'h00;
          bit_cnt_d = 5'd0;
          csn_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          sclk_d = 1'b1;
          if (bit_cnt_q >= 5'(RD_FIRST_BIT)) rx_d = {rx_q[6:0], miso};
        end else if (fall) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(FRAME_LEN - 1)) begin
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[14];
          end
        end
      end
      ST_HOLD: begin
        if (rise) begin
          state_d = ST_GAP;
          csn_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (fall) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (rnw_q == RNW_READ) rd_d = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      tx_q      <= 16'h0000;
      rx_q      <= 8'h00;
      rd_q      <= 8'h00;
      rnw_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      rnw_q     <= rnw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
    end
  end

  assign rd        = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign csn       = csn_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave with register memory, a
// reference register model feeding an expected queue, and a DONE-driven
// monitor comparing read data, captured frames and frame timing.
module tb_spi_master;

  localparam int D  = 2;
  localparam int D1 = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n = 1'b0;
  logic       req = 1'b0, rnw = 1'b0, miso = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wd = 8'd0;
  logic [7:0] rd;
  logic       busy, done, sclk, mosi, csn;
  logic [2:0] dbg_state;

  logic       req1 = 1'b0, miso1 = 1'b0;
  logic [7:0] rd1;
  logic       busy1, done1, sclk1, mosi1, csn1;
  logic [2:0] dbg_state1;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rnw(rnw), .addr(addr), .wd(wd),
    .rd(rd), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
    .miso(miso), .csn(csn), .dbg_state(dbg_state)
  );

  spi_master #(.CLK_DIV(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .rnw(rnw), .addr(addr), .wd(wd),
    .rd(rd1), .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1),
    .miso(miso1), .csn(csn1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;
  logic [23:0] exp_q[$];          // {expected frame[15:0], expected rd[7:0]}
  logic [7:0]  ref_mem[128];
  logic [7:0]  slave_mem[128];
  logic [7:0]  ref_rd;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  // ---------------- slave model + monitor ----------------
  logic        prev_csn = 1'b1, prev_sclk = 1'b0, have_rise = 1'b0, busy_chk = 1'b0;
  logic        edge_err = 1'b0;
  int          s_cnt = 0, t_fall = 0, t_rise = 0, last_edge = 0;
  logic [15:0] s_bits = 16'h0, last_frame = 16'h0;
  logic [7:0]  s_rdval = 8'h0;
  logic [23:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_cnt = 0; have_rise = 1'b0; prev_csn = 1'b1; prev_sclk = 1'b0;
      busy_chk = 1'b0; miso = 1'b0;
    end else begin
      if (busy_chk) check("busy_after_done", busy, 0);
      busy_chk = 1'b0;
      if (prev_csn && !csn) begin
        t_fall = cyc; s_cnt = 0; edge_err = 1'b0; last_edge = cyc;
        if (have_rise) check("csn_gap_ok", int'((cyc - t_rise) >= 2 * D), 1);
      end
      if (!prev_sclk && sclk) begin
        if (cyc - last_edge != D) edge_err = 1'b1;
        last_edge = cyc;
        s_bits = {s_bits[14:0], mosi};
        s_cnt++;
      end
      if (prev_sclk && !sclk) begin
        if (cyc - last_edge != D) edge_err = 1'b1;
        last_edge = cyc;
        if (s_cnt == 8) s_rdval = slave_mem[s_bits[6:0]];
        if (s_cnt >= 8 && s_cnt < 16) miso = s_rdval[7 - (s_cnt - 8)];
        else miso = 1'b0;
      end
      if (!prev_csn && csn) begin
        t_rise = cyc; have_rise = 1'b1; last_frame = s_bits;
        if (s_cnt == 16) begin
          check("csn_low_len", cyc - t_fall, 33 * D);
          if (s_bits[15]) slave_mem[s_bits[14:8]] = s_bits[7:0];
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("rd_value", rd, e[7:0]);
          check("frame_bits", last_frame, e[23:8]);
          check("done_time", cyc - t_fall, 34 * D);
          check("sclk_half_period", edge_err, 0);
          check("busy_at_done", busy, 1);
          check("mosi_idle", mosi, 0);
          busy_chk = 1'b1;
        end
      end
      prev_csn = csn; prev_sclk = sclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int i = 0; i < 100 * D + 50; i++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    fail_now("wait_idle");
  endtask

  // Returns on the negedge of the cycle following DONE.
  task automatic wait_done();
    for (int i = 0; i < 100 * D + 50; i++) begin
      if (done) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    fail_now("wait_done");
  endtask

  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w, input bit b2b);
    logic [7:0] rexp;
    if (b2b) wait_done();
    else wait_idle();
    req = 1'b1; rnw = r; addr = a; wd = w;
    rexp = r ? ref_mem[a] : ref_rd;
    if (r) ref_rd = ref_mem[a];
    else ref_mem[a] = w;
    exp_q.push_back({~r, a, (r ? 8'h00 : w), rexp});
    @(negedge clk);
    // scramble inputs while the frame runs; captured fields must hold
    req = 1'b0; rnw = 1'($urandom); addr = 7'($urandom); wd = 8'($urandom);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 100 * D; i++) begin
      if (s_cnt >= n) return;
      @(negedge clk);
    end
    fail_now("wait_bits");
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] old_val;
  int rises, t_r, hi_len;
  logic first_mosi, seen_done1, ps1;

  initial begin
    for (int i = 0; i < 128; i++) slave_mem[i] = 8'($urandom);
    slave_mem[7'h7F] = 8'h3C;
    slave_mem[7'h33] = 8'h11;
    for (int i = 0; i < 128; i++) ref_mem[i] = slave_mem[i];
    ref_rd = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_csn", csn, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", rd, 0);
    rst_n = 1'b1;

    issue(1'b0, 7'h15, 8'hA5, 1'b0);      // first REQ right after release
    issue(1'b1, 7'h15, 8'h00, 1'b0);
    issue(1'b1, 7'h7F, 8'h00, 1'b0);

    // REQ pulsed mid-frame must be dropped
    issue(1'b0, 7'h22, 8'h5A, 1'b0);
    wait_bits(4);
    req = 1'b1; rnw = 1'b0; addr = 7'h01; wd = 8'hEE;
    @(negedge clk);
    req = 1'b0;

    // REQ during the DONE cycle must be dropped
    issue(1'b1, 7'h22, 8'h00, 1'b0);
    for (int i = 0; i < 100 * D && !done; i++) @(negedge clk);
    req = 1'b1; rnw = 1'b0; addr = 7'h02; wd = 8'h77;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("done_cycle_req_ignored", busy, 0);

    // back-to-back write then read
    issue(1'b0, 7'h40, 8'hC3, 1'b0);
    issue(1'b1, 7'h40, 8'h00, 1'b1);

    for (int n = 0; n < 12; n++)
      issue(1'($urandom), 7'($urandom_range(0, 127)), 8'($urandom), bit'($urandom_range(0, 1)));

    // reset during bit 9 of a write: aborted, slave never written
    issue(1'b0, 7'h33, 8'h99, 1'b0);
    old_val = 8'h11;
    wait_bits(9);
    #2 rst_n = 1'b0;
    #1;
    check("abort_csn", csn, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    void'(exp_q.pop_back());
    ref_mem[7'h33] = old_val;
    ref_rd = 8'h00;
    repeat (3) @(negedge clk);
    check("abort_done", done, 0);
    check("abort_rd", rd, 0);
    rst_n = 1'b1;

    issue(1'b1, 7'h33, 8'h00, 1'b0);
    issue(1'b1, 7'h01, 8'h00, 1'b0);
    issue(1'b1, 7'h02, 8'h00, 1'b0);
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    // slow divider read of 0xFF
    rnw = 1'b1; addr = 7'h7F; wd = 8'h00; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    rises = 0; hi_len = 0; t_r = 0; first_mosi = 1'b1; seen_done1 = 1'b0; ps1 = 1'b0;
    for (int i = 0; i < 40 * D1 && !seen_done1; i++) begin
      @(negedge clk);
      if (!ps1 && sclk1) begin
        rises++;
        if (rises == 1) begin first_mosi = mosi1; t_r = cyc; end
      end
      if (ps1 && !sclk1) begin
        if (rises == 1) hi_len = cyc - t_r;
        miso1 = (rises >= 8 && rises < 16);
      end
      ps1 = sclk1;
      if (done1) seen_done1 = 1'b1;
    end
    if (!seen_done1) fail_now("slow_done");
    check("slow_rd", rd1, 8'hFF);
    check("slow_half_period", hi_len, D1);
    check("slow_bit0_read", first_mosi, 0);
    check("slow_rises", rises, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, CLK cycles per SCLK half-period (legal 2..255).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. CLK input 1: system clock, all logic on posedge.
REQ-003 RSTN input 1: asynchronous active-low reset.
REQ-004 REQ input 1: start-transaction strobe, sampled only in IDLE.
REQ-005 RNW input 1: 1 = register read, 0 = register write, captured with REQ.
REQ-006 ADDR input 7: register address, captured with REQ.
REQ-007 WD input 8: write data, captured with REQ.
REQ-008 RD output 8: read data, valid from DONE until the next DONE.
REQ-009 BUSY output 1: high from the cycle after an accepted REQ through the DONE cycle.
REQ-010 DONE output 1: single-cycle pulse at transaction end.
REQ-011 SCLK output 1: SPI clock, mode 0, idle low.
REQ-012 MOSI output 1: serial data to slave.
REQ-013 MISO input 1: serial data from slave.
REQ-014 CSN output 1: active-low chip select, idle high.

Function
REQ-015 FSM states IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on REQ, SETUP->SHIFT after CLK_DIV cycles, SHIFT->HOLD after 16th SCLK falling edge, HOLD->GAP after CLK_DIV cycles, GAP->IDLE after CLK_DIV cycles.
REQ-016 Frame is 16 bits MSB first: bit0 = ~RNW (1 write, 0 read), bits1..7 = ADDR[6:0], bits8..15 = WD[7:0] for write, 0 for read.
REQ-017 CSN falls at T0 (cycle after REQ accepted); bit i SCLK rises at T0+(2i+1)*CLK_DIV and falls at T0+(2i+2)*CLK_DIV, i = 0..15.
REQ-018 MOSI presents bit0 at T0 and changes only on SCLK falling edges thereafter; MOSI = 0 outside SETUP/SHIFT.
REQ-019 CSN rises at T0+33*CLK_DIV; DONE pulses at T0+34*CLK_DIV, BUSY falls the cycle after.
REQ-020 Read: MISO sampled on SCLK rising edges of bits 8..15 into RD MSB first; RD updated on the DONE cycle only.
REQ-021 Write: RD unchanged.
REQ-022 REQ while BUSY is ignored, not queued; REQ in the DONE cycle is ignored.
REQ-023 Back-to-back: REQ asserted the cycle after DONE starts a new frame; CSN stays high at least 2*CLK_DIV cycles between frames.
REQ-024 Captured RNW/ADDR/WD are held internally; input changes during BUSY do not affect the frame.
REQ-025 Bit counter 5 bits, counts 0..16, no wrap; divider counter 8 bits, reloads at CLK_DIV-1.

Reset
REQ-026 RSTN low forces immediately: state IDLE, CSN 1, SCLK 0, MOSI 0, BUSY 0, DONE 0, RD 0x00, counters 0.
REQ-027 Reset mid-frame aborts with no DONE; CSN high resets the slave frame.
REQ-028 First REQ accepted one cycle after RSTN release.

Structure
REQ-029 Shared package spi_pkg holds FSM state encoding, frame length 16, and read/write bit encoding constants.
REQ-030 One sub-module spi_clk_gen: half-period tick generator with enable, outputs rise/fall strobes.

Verification
REQ-031 Write CLK_DIV=2, ADDR=0x15, WD=0xA5 -> MOSI 1,0010101,10100101; CSN low 66 cycles; DONE at T0+68; slave sees WEN with WD=0xA5 at ADDR 0x15.
REQ-032 Read ADDR=0x7F, slave RD=0x3C -> bit0 = 0, RD=0x3C at DONE, BUSY low next cycle.
REQ-033 REQ pulsed during SHIFT with ADDR=0x01 -> ignored, frame to original address completes unchanged, single DONE.
REQ-034 Back-to-back write then read, REQ the cycle after DONE -> CSN high >= 4 cycles (CLK_DIV=2), both transactions correct.
REQ-035 RSTN low at bit 9 of a write -> CSN 1, SCLK 0 same cycle, no DONE, slave WEN never asserted.
REQ-036 CLK_DIV=255 read of 0xFF -> SCLK half-period 255 cycles, RD=0xFF.
